// File: rtl/tdm_demux.sv
// Receive end of a 4-lane TDM link: gathers one beat per valid cycle into
// shadow registers and presents a whole frame on A/B/C/E with a one-cycle strobe.
module tdm_demux #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sync,
    input  logic [WIDTH-1:0] D,
    output logic [1:0]       S,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] E,
    output logic             out_valid,
    output logic             sync_err
);

    // Input handshake: there is no ready; every cycle with in_valid=1 is a
    // consumed beat, and in_sync is meaningful only alongside in_valid.
    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       s_q, s_d;
    logic [WIDTH-1:0] sh0_q, sh0_d;
    logic [WIDTH-1:0] sh1_q, sh1_d;
    logic [WIDTH-1:0] sh2_q, sh2_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] e_q, e_d;
    logic             out_valid_q, out_valid_d;
    logic             sync_err_q, sync_err_d;

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        sh0_d       = sh0_q;
        sh1_d       = sh1_q;
        sh2_d       = sh2_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        e_d         = e_q;
        out_valid_d = 1'b0;
        sync_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_sync) begin
                        sh0_d   = D;
                        s_d     = 2'd1;
                        state_d = COLLECT;
                    end else begin
                        sync_err_d = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    if (in_sync) begin
                        // Early sync truncates the frame; the new beat restarts lane 0.
                        sync_err_d = 1'b1;
                        sh0_d      = D;
                        s_d        = 2'd1;
                    end else begin
                        case (s_q)
                            2'd1: begin
                                sh1_d = D;
                                s_d   = 2'd2;
                            end
                            2'd2: begin
                                sh2_d = D;
                                s_d   = 2'd3;
                            end
                            2'd3: begin
                                // Lane 3 goes straight to E; no shadow needed.
                                a_d         = sh0_q;
                                b_d         = sh1_q;
                                c_d         = sh2_q;
                                e_d         = D;
                                out_valid_d = 1'b1;
                                s_d         = 2'd0;
                                state_d     = IDLE;
                            end
                            default: begin
                                s_d     = 2'd0;
                                state_d = IDLE;
                            end
                        endcase
                    end
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= 2'd0;
            sh0_q       <= '0;
            sh1_q       <= '0;
            sh2_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            e_q         <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            sh0_q       <= sh0_d;
            sh1_q       <= sh1_d;
            sh2_q       <= sh2_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            e_q         <= e_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign S         = s_q;
    assign A         = a_q;
    assign B         = b_q;
    assign C         = c_q;
    assign E         = e_q;
    assign out_valid = out_valid_q;
    assign sync_err  = sync_err_q;

    // Completion and an error come from mutually exclusive branches.
    a_no_dual_pulse: assert property (@(posedge clk) disable iff (rst)
        !(out_valid_q && sync_err_q));

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed scenarios plus random traffic
// compared against a frame-level reference model.
module tb_tdm_demux;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_sync = 1'b0;
    logic [W-1:0] D = '0;
    logic [1:0]   S;
    logic [W-1:0] A, B, C, E;
    logic         out_valid, sync_err;

    int total = 0;
    int bad   = 0;

    // Reference model: lanes of the frame in progress (empty = waiting for sync).
    int           m_lanes[$];
    logic [W-1:0] exp_a = '0, exp_b = '0, exp_c = '0, exp_e = '0;
    logic         exp_ov = 1'b0, exp_err = 1'b0;
    logic [1:0]   exp_s = 2'd0;

    tdm_demux #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sync(in_sync), .D(D),
        .S(S), .A(A), .B(B), .C(C), .E(E), .out_valid(out_valid), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model over the edge, settle #1 after.
    task automatic step(input logic r, input logic v, input logic s, input logic [W-1:0] d);
        rst = r; in_valid = v; in_sync = s; D = d;
        @(posedge clk);
        exp_ov = 1'b0;
        exp_err = 1'b0;
        if (r) begin
            m_lanes.delete();
            exp_a = '0; exp_b = '0; exp_c = '0; exp_e = '0;
        end else if (v) begin
            if (s) begin
                if (m_lanes.size() != 0) exp_err = 1'b1;
                m_lanes.delete();
                m_lanes.push_back(int'(d));
            end else if (m_lanes.size() == 0) begin
                exp_err = 1'b1;
            end else begin
                m_lanes.push_back(int'(d));
                if (m_lanes.size() == 4) begin
                    exp_a = W'(m_lanes[0]); exp_b = W'(m_lanes[1]);
                    exp_c = W'(m_lanes[2]); exp_e = W'(m_lanes[3]);
                    exp_ov = 1'b1;
                    m_lanes.delete();
                end
            end
        end
        exp_s = 2'(m_lanes.size());
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        step(1, 1, 1, 4'd7);
        total++; if (S !== 2'd0) begin bad++; $display("FAIL reset_s got=%0d exp=0", S); end
        total++; if ({A, B, C, E} !== '0) begin bad++; $display("FAIL reset_abce got=%h exp=0", {A, B, C, E}); end
        total++; if (out_valid !== 1'b0 || sync_err !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b exp=00", out_valid, sync_err); end
    endtask

    task automatic test_basic_frame();
        step(0, 1, 1, 4'd1);
        total++; if (S !== 2'd1 || out_valid !== 1'b0) begin bad++; $display("FAIL basic_lane0 s=%0d ov=%b exp s=1 ov=0", S, out_valid); end
        step(0, 1, 0, 4'd2);
        step(0, 1, 0, 4'd4);
        total++; if (S !== 2'd3 || out_valid !== 1'b0) begin bad++; $display("FAIL basic_lane2 s=%0d ov=%b exp s=3 ov=0", S, out_valid); end
        step(0, 1, 0, 4'd8);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_ov got=%b exp=1", out_valid); end
        total++; if ({A, B, C, E} !== 16'h1248) begin bad++; $display("FAIL basic_abce got=%h exp=1248", {A, B, C, E}); end
        total++; if (S !== 2'd0 || sync_err !== 1'b0) begin bad++; $display("FAIL basic_s_err s=%0d err=%b exp s=0 err=0", S, sync_err); end
        step(0, 0, 0, 4'd0);
        total++; if (out_valid !== 1'b0 || {A, B, C, E} !== 16'h1248) begin bad++; $display("FAIL basic_after ov=%b abce=%h exp ov=0 abce=1248", out_valid, {A, B, C, E}); end
    endtask

    task automatic test_stall();
        step(1, 0, 0, 0);
        step(0, 1, 1, 4'd1);
        step(0, 1, 0, 4'd2);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 4'd15);
            total++; if (S !== 2'd2) begin bad++; $display("FAIL stall_s cyc=%0d got=%0d exp=2", i, S); end
            total++; if (out_valid !== 1'b0 || {A, B, C, E} !== 16'h0000) begin bad++; $display("FAIL stall_out cyc=%0d ov=%b abce=%h exp ov=0 abce=0000", i, out_valid, {A, B, C, E}); end
        end
        step(0, 1, 0, 4'd4);
        total++; if (out_valid !== 1'b0 || S !== 2'd3) begin bad++; $display("FAIL stall_lane2 ov=%b s=%0d exp ov=0 s=3", out_valid, S); end
        step(0, 1, 0, 4'd8);
        total++; if (out_valid !== 1'b1 || {A, B, C, E} !== 16'h1248) begin bad++; $display("FAIL stall_done ov=%b abce=%h exp ov=1 abce=1248", out_valid, {A, B, C, E}); end
    endtask

    task automatic test_early_sync();
        step(0, 1, 1, 4'd1); step(0, 1, 0, 4'd2); step(0, 1, 0, 4'd4); step(0, 1, 0, 4'd8);
        step(0, 1, 1, 4'd15);
        step(0, 1, 0, 4'd3);
        total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL early_noerr got=%b exp=0", sync_err); end
        step(0, 1, 1, 4'd5);
        total++; if (sync_err !== 1'b1) begin bad++; $display("FAIL early_err got=%b exp=1", sync_err); end
        total++; if (S !== 2'd1 || {A, B, C, E} !== 16'h1248) begin bad++; $display("FAIL early_hold s=%0d abce=%h exp s=1 abce=1248", S, {A, B, C, E}); end
        step(0, 1, 0, 4'd6);
        total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL early_err_pulse got=%b exp=0", sync_err); end
        step(0, 1, 0, 4'd7);
        step(0, 1, 0, 4'd9);
        total++; if (out_valid !== 1'b1 || {A, B, C, E} !== 16'h5679) begin bad++; $display("FAIL early_done ov=%b abce=%h exp ov=1 abce=5679", out_valid, {A, B, C, E}); end
    endtask

    task automatic test_idle_nosync();
        step(0, 0, 0, 0);
        step(0, 1, 0, 4'd10);
        total++; if (sync_err !== 1'b1 || S !== 2'd0) begin bad++; $display("FAIL idle_err err=%b s=%0d exp err=1 s=0", sync_err, S); end
        total++; if (out_valid !== 1'b0 || {A, B, C, E} !== 16'h5679) begin bad++; $display("FAIL idle_out ov=%b abce=%h exp ov=0 abce=5679", out_valid, {A, B, C, E}); end
        step(0, 0, 0, 0);
        total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL idle_err_pulse got=%b exp=0", sync_err); end
    endtask

    task automatic test_reset_midframe();
        step(0, 1, 1, 4'd9);
        step(0, 1, 0, 4'd3);
        step(1, 1, 0, 4'd4);
        total++; if (S !== 2'd0 || {A, B, C, E} !== '0) begin bad++; $display("FAIL rstmid_clear s=%0d abce=%h exp s=0 abce=0000", S, {A, B, C, E}); end
        total++; if (out_valid !== 1'b0 || sync_err !== 1'b0) begin bad++; $display("FAIL rstmid_pulses got=%b%b exp=00", out_valid, sync_err); end
        step(0, 0, 0, 0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_noov got=%b exp=0", out_valid); end
        step(0, 1, 1, 4'd8); step(0, 1, 0, 4'd4); step(0, 1, 0, 4'd2); step(0, 1, 0, 4'd1);
        total++; if (out_valid !== 1'b1 || {A, B, C, E} !== 16'h8421) begin bad++; $display("FAIL rstmid_frame ov=%b abce=%h exp ov=1 abce=8421", out_valid, {A, B, C, E}); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] seq [8];
        int pulses[$];
        seq = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd8, 4'd4, 4'd2, 4'd1};
        step(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, (i % 4) == 0, seq[i]);
            if (out_valid === 1'b1) pulses.push_back(i);
            if (i == 3) begin
                total++; if ({A, B, C, E} !== 16'h1248) begin bad++; $display("FAIL b2b_first got=%h exp=1248", {A, B, C, E}); end
            end
            if (i == 7) begin
                total++; if ({A, B, C, E} !== 16'h8421) begin bad++; $display("FAIL b2b_second got=%h exp=8421", {A, B, C, E}); end
            end
        end
        total++;
        if (pulses.size() != 2) begin
            bad++; $display("FAIL b2b_count got=%0d exp=2", pulses.size());
        end else if (pulses[0] != 3 || pulses[1] - pulses[0] != 4) begin
            bad++; $display("FAIL b2b_spacing first=%0d gap=%0d exp first=3 gap=4", pulses[0], pulses[1] - pulses[0]);
        end
    endtask

    task automatic test_random();
        step(1, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 4) == 0, W'($urandom_range(0, 15)));
            total++;
            if (S !== exp_s || out_valid !== exp_ov || sync_err !== exp_err) begin
                bad++;
                $display("FAIL rand_ctrl cyc=%0d s/ov/err got=%0d/%b/%b exp=%0d/%b/%b", i, S, out_valid, sync_err, exp_s, exp_ov, exp_err);
            end
            total++;
            if ({A, B, C, E} !== {exp_a, exp_b, exp_c, exp_e}) begin
                bad++;
                $display("FAIL rand_data cyc=%0d got=%h exp=%h", i, {A, B, C, E}, {exp_a, exp_b, exp_c, exp_e});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_stall();
        test_early_sync();
        test_idle_nosync();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division 1-to-4 demultiplexer: the receive end of a 4-lane TDM link whose transmit side is our 4-to-1 mux.
- Accepts one WIDTH-bit beat per valid cycle on a single input D. A sync marker identifies lane 0.
- Lanes are collected into shadow registers, then presented together on parallel outputs A, B, C, E with a one-cycle frame strobe.
- Sits downstream of the mux/serial link, feeding parallel consumers.

Parameters:
- WIDTH, 4, bit width of each lane and of the serial input D.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  D carries a valid beat this cycle.
- in_sync  input  1  qualifies the current valid beat as lane 0, i.e. start of frame. Ignored when in_valid=0.
- D  input  WIDTH  serial lane data.
- S  output  2  lane index the next accepted beat will be written to.
- A  output  WIDTH  lane 0 of the last completed frame.
- B  output  WIDTH  lane 1 of the last completed frame.
- C  output  WIDTH  lane 2 of the last completed frame.
- E  output  WIDTH  lane 3 of the last completed frame.
- out_valid  output  1  one-cycle pulse: A/B/C/E just updated with a new frame.
- sync_err  output  1  one-cycle pulse: protocol violation detected.

Behaviour:
- Single clock domain. Reset is synchronous, active-high. While rst=1 at an edge:
  - state=IDLE, S=0
  - A/B/C/E=0, shadow registers=0
  - out_valid=0, sync_err=0
- Reset mid-frame discards the partial frame. No out_valid follows.
- States:
  - IDLE: waiting for sync.
  - COLLECT: lanes 1..3 pending.
- IDLE:
  - in_valid & in_sync: shadow0<=D, S<=1, go to COLLECT.
  - in_valid & !in_sync: beat dropped, sync_err pulses next cycle, S stays 0.
  - !in_valid: no change.
- COLLECT:
  - in_valid & !in_sync: shadow[S]<=D, S<=S+1.
  - Beat accepted with S=3 completes the frame:
    - A/B/C/E <= shadow0..2 and D, on the same edge.
    - out_valid=1 for exactly the following cycle.
    - S wraps to 0; return to IDLE.
  - in_valid & in_sync (early sync, frame truncated):
    - sync_err pulses.
    - Partial frame discarded; A/B/C/E unchanged.
    - Restart: shadow0<=D, S<=1, stay in COLLECT.
  - !in_valid: stall. State, S and shadow registers hold indefinitely.
- Latency:
  - out_valid and the new A/B/C/E are visible in the cycle after the lane-3 beat is sampled.
  - Minimum frame period is 4 valid cycles.
  - Back-to-back frames are allowed: sync in the cycle right after lane 3 is accepted normally.
- Output holding:
  - A/B/C/E change only on frame completion or reset. They hold otherwise.
  - out_valid and sync_err are registered single-cycle pulses, never held.
- Both pulses can be asserted in the same cycle only if completion and an error coincide. This is impossible by construction, and an assertion checks it.
- No arithmetic beyond the 2-bit S counter, which wraps modulo 4.

Test Plan:
- Reset, then sync+D=1, then D=2, 4, 8 on consecutive valid cycles -> next cycle A=1, B=2, C=4, E=8, out_valid=1 for 1 cycle, S=0.
- Same frame with in_valid low for 3 cycles between lanes 1 and 2 -> S holds at 2 during the gap, outputs unchanged until the completion cycle, then A=1, B=2, C=4, E=8.
- Load a frame of 1,2,4,8. Then sync+D=15, D=3, then sync+D=5, D=6, D=7, D=9:
  - The second sync (at D=5) -> sync_err pulse.
  - A=1, B=2, C=4, E=8 hold through the truncated frame.
  - Completion -> A=5, B=6, C=7, E=9.
- In IDLE, in_valid=1, in_sync=0, D=10 -> sync_err pulse, S=0, no out_valid, outputs unchanged.
- rst asserted after lanes 0 and 1 of a frame -> next cycle all outputs 0, S=0. A following full frame 8,4,2,1 gives A=8, B=4, C=2, E=1.
- Two back-to-back frames (1,2,4,8 then 8,4,2,1 with no idle cycle) -> two out_valid pulses exactly 4 cycles apart, outputs update each time.
